// File: rtl/ram_sdp_arbiter.sv
// Two-requester front end for a simple-dual-port RAM: independent round-robin
// arbitration on the write and read ports, with per-requester read return strobes.
module ram_sdp_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wr_req,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  output logic [1:0]        wr_gnt,
  input  logic [1:0]        rd_req,
  input  logic [2*AW-1:0]   rd_addr,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [2*DW-1:0]   rd_data
);

  localparam int DEPTH = 1 << AW;

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  // The requester just served loses priority; an idle cycle leaves it alone.
  function automatic logic prio_next(input logic [1:0] gnt, input logic prio);
    logic nxt;
    case (gnt)
      2'b01:   nxt = 1'b1;
      2'b10:   nxt = 1'b0;
      default: nxt = prio;
    endcase
    return nxt;
  endfunction

  logic              wprio_q, wprio_d;
  logic              rprio_q, rprio_d;
  logic [1:0]        wr_gnt_s, rd_gnt_s;
  logic              wr_en_s, rd_en_s;
  logic [AW-1:0]     waddr_s, raddr_s;
  logic [DW-1:0]     wdata_s;
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic [2*DW-1:0]   rd_hold_q, rd_hold_d;
  logic [2*DW-1:0]   rd_data_s;
  logic [DW-1:0]     ram_dout_q;
  logic [DW-1:0]     mem [DEPTH];

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    wr_gnt_s = 2'b00;
    rd_gnt_s = 2'b00;
    if (rst_n) begin
      wr_gnt_s = rr_pick(wr_req, wprio_q);
      rd_gnt_s = rr_pick(rd_req, rprio_q);
    end else begin
      wr_gnt_s = 2'b00;
      rd_gnt_s = 2'b00;
    end
  end

  // Steer the granted requester's address and data onto the RAM ports.
  always_comb begin
    wr_en_s = |wr_gnt_s;
    rd_en_s = |rd_gnt_s;
    if (wr_gnt_s[1]) begin
      waddr_s = wr_addr[AW +: AW];
      wdata_s = wr_data[DW +: DW];
    end else begin
      waddr_s = wr_addr[0 +: AW];
      wdata_s = wr_data[0 +: DW];
    end
    if (rd_gnt_s[1]) begin
      raddr_s = rd_addr[AW +: AW];
    end else begin
      raddr_s = rd_addr[0 +: AW];
    end
  end

  // Fresh RAM data is shown in the valid cycle; otherwise each slice replays its last value.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < 2; i++) begin
      if (rd_valid_q[i]) begin
        rd_data_s[i*DW +: DW] = ram_dout_q;
      end else begin
        rd_data_s[i*DW +: DW] = rd_hold_q[i*DW +: DW];
      end
    end
  end

  // Next-state for priorities, the valid pipeline and the per-requester hold registers.
  always_comb begin
    wprio_d    = prio_next(wr_gnt_s, wprio_q);
    rprio_d    = prio_next(rd_gnt_s, rprio_q);
    rd_valid_d = rd_gnt_s;
    rd_hold_d  = rd_data_s;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wprio_q    <= 1'b0;
      rprio_q    <= 1'b0;
      rd_valid_q <= 2'b00;
      rd_hold_q  <= '0;
    end else begin
      wprio_q    <= wprio_d;
      rprio_q    <= rprio_d;
      rd_valid_q <= rd_valid_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  // RAM array kept free of reset so it maps onto block RAM; read-first on collision.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[waddr_s] <= wdata_s;
    end
    if (rd_en_s) begin
      ram_dout_q <= mem[raddr_s];
    end
  end

  assign wr_gnt   = wr_gnt_s;
  assign rd_gnt   = rd_gnt_s;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_s;

endmodule

// File: doc/ram_sdp_arbiter.md
# ram_sdp_arbiter

Two-requester arbiter and sequencer in front of a single-clock simple-dual-port block RAM (one write port, one read port, 1024 x 16 by default). Each port has its own round-robin arbiter, so two masters can share the RAM with a write and a read completing every cycle. Read data comes back on per-requester valid strobes. The block contains the RAM array, coded for block-RAM inference, and sits between two DMA or engine clients and the storage.

## Interface
- AW, 10, address width; depth is 2**AW
- DW, 16, data width
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_req  in  2  write request, bit i belongs to requester i
- wr_addr  in  2*AW  requester i address at [i*AW +: AW]
- wr_data  in  2*DW  requester i data at [i*DW +: DW]
- wr_gnt  out  2  write grant, one-hot or zero, combinational
- rd_req  in  2  read request per requester
- rd_addr  in  2*AW  requester i read address at [i*AW +: AW]
- rd_gnt  out  2  read grant, one-hot or zero, combinational
- rd_valid  out  2  one-cycle pulse: read data for requester i is valid
- rd_data  out  2*DW  requester i read data at [i*DW +: DW]

## Operation
- Handshake: a requester holds req, addr and data stable until it sees gnt high in the same cycle. A transfer occurs in a cycle where req&gnt is high. Requests are never queued.
- The write port and the read port arbitrate independently. Each has a 1-bit priority register, wprio or rprio, reset to 0.
- Arbitration per port:
  - Both requesting: grant the requester named by prio.
  - One requesting: grant it.
  - None requesting: gnt = 0.
- Priority update: on any grant to index g, prio <= ~g. With no grant, prio holds.
- Write: the granted requester's data is written to mem[addr] at the end of the grant cycle.
- Read: the granted requester's address is sampled. In the next cycle, rd_valid[g] = 1 and rd_data slice g = mem[addr].
- rd_data slice i holds its last value until the next read for requester i completes.
- Read/write collision: same address, both granted in the same cycle. The read returns the old contents (read-first). The new value is visible to reads granted in the following cycle or later.
- Addresses are used modulo 2**AW. There is no range checking.
- While rst_n = 0:
  - wr_gnt = 0 and rd_gnt = 0 (gated combinationally).
  - No RAM write occurs.
- RAM contents are not reset.

## Timing
- Reset values: wr_gnt = 0, rd_gnt = 0, rd_valid = 0, rd_data = 0, wprio = 0, rprio = 0.
- Grant latency: 0 cycles, combinational from req, prio and rst_n.
- Write latency: 1 edge. Read latency: 1 cycle from the grant to rd_valid.
- Throughput: 1 write and 1 read per cycle sustained. Under continuous contention, grants alternate 01, 10, 01, ...
- Asynchronous reset during a read: if rst_n falls after a read grant and before the next edge, the read is dropped. rd_valid stays 0 and nothing is ever returned.
- Asynchronous reset during a write: a write granted in a cycle where rst_n falls before the edge is not committed.
- After rst_n rises, the first grants follow prio = 0.

## Test plan
- Reset: hold rst_n = 0 with all requests high.
  - Required: wr_gnt = 0, rd_gnt = 0, rd_valid = 0, rd_data = 0.
  - After release with both requesting, the first grants are 2'b01.
- Write then read: requester 0 writes 0xA5A5 to 0x005. Next cycle, requester 1 reads 0x005.
  - Required: rd_gnt = 2'b10; one cycle later rd_valid = 2'b10 and rd_data[31:16] = 0xA5A5.
  - Required: rd_valid[0] stays 0 throughout.
- Write contention: both requesters hold write requests for 4 cycles, to 0x010 (data 0x1111) and 0x020 (data 0x2222).
  - Required: wr_gnt = 01, 10, 01, 10.
  - Required: readback gives 0x1111 and 0x2222.
- Collision: preload mem[0x3FF] = 0x1234. In the same cycle, requester 0 writes 0xBEEF to 0x3FF and requester 1 reads 0x3FF.
  - Required: the read returns 0x1234.
  - Required: a read granted in the next cycle returns 0xBEEF.
- Mid-operation reset: requester 0 read is granted, then rst_n pulses low before the edge.
  - Required: rd_valid stays 0 and prio returns to 0.
  - Required: a write granted in that cycle is not committed; a read shows the prior value.
- Read-side fairness and hold: requester 0 requests continuously while requester 1 requests every other cycle.
  - Required: requester 1 is granted on every cycle it requests.
  - Required: rd_data for the idle requester holds its old value.
